ldpc_rd_seq_gen: RTL and testbench

Parametrised read sequencer for the LDPC decoder output stage.
- On `start`, walks an external sequence table (entries `0 .. LEN(rate)-1`) with one-cycle read latency.
- Emits, per beat, a memory row address and a one-hot bank select across NBANK parallel banks.
- Generalises the fixed 36-bank, 2-rate, free-running output reader: 4 rate modes, start/done control, `out_ready` backpressure, abort, and select-range checking.

---
 rtl/ldpc_rd_seq_gen.sv | 147 ++++++++++++++
 tb/tb_ldpc_rd_seq_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_rd_seq_gen.sv
// ldpc_rd_seq_gen: read sequencer for the LDPC decoder output stage.
// Walks an external sequence table (one-cycle read latency) on start and
// emits per beat a row address and a one-hot bank select, with out_ready
// backpressure, abort, and out-of-range select detection.
// Optional build macro: LDPC_RD_SEQ_PARCHK_EN adds an even-parity MSB on
// table_q and a sticky par_err output.
module ldpc_rd_seq_gen #(
  parameter int unsigned A_WID   = 8,
  parameter int unsigned NBANK   = 36,
  parameter int unsigned SEL_WID = 6,
  parameter int unsigned CNT_WID = 13,
  parameter int unsigned LEN0    = 4608,
  parameter int unsigned LEN1    = 6912,
  parameter int unsigned LEN2    = 0,
  parameter int unsigned LEN3    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [1:0]               rate,
  input  logic                     abort,
  input  logic                     out_ready,
  output logic [CNT_WID-1:0]       table_addr,
  output logic                     table_rd_en,
`ifdef LDPC_RD_SEQ_PARCHK_EN
  input  logic [A_WID+SEL_WID:0]   table_q,
  output logic                     par_err,
`else
  input  logic [A_WID+SEL_WID-1:0] table_q,
`endif
  output logic [A_WID-1:0]         out_addr,
  output logic [NBANK-1:0]         out_rd,
  output logic                     out_valid,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     sel_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_WID:0] LEN_ONE = (CNT_WID+1)'(1);
  localparam logic [SEL_WID:0] NB      = (SEL_WID+1)'(NBANK);

  state_t             state, state_d;
  logic [CNT_WID-1:0] cnt;
  logic [CNT_WID:0]   len_q, len_in;
  logic               s1_valid, s1_last;
  logic               en, start_go, cnt_is_last;
  logic [A_WID-1:0]   row;
  logic [SEL_WID-1:0] sel;
  logic               sel_ok;
  logic [NBANK-1:0]   rd_dec;

  assign row         = table_q[A_WID+SEL_WID-1:SEL_WID];
  assign sel         = table_q[SEL_WID-1:0];
  assign sel_ok      = ({1'b0, sel} < NB);
  assign rd_dec      = sel_ok ? (NBANK'(1) << sel) : '0;
  assign en          = !out_valid || out_ready;
  assign table_rd_en = (state == S_RUN) && en;
  assign table_addr  = cnt;
  assign busy        = (state != S_IDLE);
  assign start_go    = (state == S_IDLE) && start && !abort;
  assign cnt_is_last = ({1'b0, cnt} == (len_q - LEN_ONE));

  // Sequence length selected by the rate input (latched on accepted start).
  always_comb begin
    len_in = '0;
    case (rate)
      2'd0:    len_in = (CNT_WID+1)'(LEN0);
      2'd1:    len_in = (CNT_WID+1)'(LEN1);
      2'd2:    len_in = (CNT_WID+1)'(LEN2);
      default: len_in = (CNT_WID+1)'(LEN3);
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = (len_in != '0) ? S_RUN : S_DONE;
      S_RUN:   if (table_rd_en && cnt_is_last) state_d = S_DRAIN;
      S_DRAIN: if (!s1_valid && (!out_valid || out_ready)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Counter, table-word tracking stage, output register and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      len_q     <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_addr  <= '0;
      out_rd    <= '0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
`ifdef LDPC_RD_SEQ_PARCHK_EN
      par_err   <= 1'b0;
`endif
    end else if (abort) begin
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      // Counter holds on the final index rather than wrapping.
      if (table_rd_en && !cnt_is_last) cnt <= cnt + CNT_WID'(1);
      if (en) begin
        s1_valid  <= table_rd_en;
        s1_last   <= table_rd_en && cnt_is_last;
        out_valid <= s1_valid;
        out_addr  <= row;
        out_rd    <= rd_dec;
        out_last  <= s1_last;
        if (s1_valid && !sel_ok) sel_err <= 1'b1;
`ifdef LDPC_RD_SEQ_PARCHK_EN
        if (s1_valid && (^table_q)) par_err <= 1'b1;
`endif
      end
      // Accepted start restarts the walk and clears sticky errors.
      if (start_go) begin
        len_q   <= len_in;
        cnt     <= '0;
        sel_err <= 1'b0;
`ifdef LDPC_RD_SEQ_PARCHK_EN
        par_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ldpc_rd_seq_gen.sv
// Directed self-checking bench for ldpc_rd_seq_gen (default parameters).
module tb_ldpc_rd_seq_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  rate = 2'd0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic [12:0] table_addr;
  logic        table_rd_en;
`ifdef LDPC_RD_SEQ_PARCHK_EN
  logic [14:0] table_q = '0;
  logic        par_err;
`else
  logic [13:0] table_q = '0;
`endif
  logic [7:0]  out_addr;
  logic [35:0] out_rd;
  logic        out_valid, out_last, busy, done, sel_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic bad5 = 1'b0;

  always #5 clk = ~clk;

  ldpc_rd_seq_gen #(.A_WID(8), .NBANK(36), .SEL_WID(6), .CNT_WID(13),
                    .LEN0(4608), .LEN1(6912), .LEN2(0), .LEN3(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rate(rate), .abort(abort),
    .out_ready(out_ready), .table_addr(table_addr), .table_rd_en(table_rd_en),
    .table_q(table_q),
`ifdef LDPC_RD_SEQ_PARCHK_EN
    .par_err(par_err),
`endif
    .out_addr(out_addr), .out_rd(out_rd), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .done(done), .sel_err(sel_err));

  // Table contents: T[i] = {i%256, i%36}, entry 5 optionally forced to sel=40.
  function automatic int e_sel(input int i);
    return (bad5 && i == 5) ? 40 : i % 36;
  endfunction
  function automatic logic [7:0] e_addr(input int i);
    return 8'(i % 256);
  endfunction
  function automatic logic [35:0] e_rd(input int i);
    logic [35:0] r = '0;
    int s = e_sel(i);
    if (s < 36) r[s] = 1'b1;
    return r;
  endfunction
  function automatic logic [13:0] t_word(input int i);
    return {8'(i % 256), 6'(e_sel(i))};
  endfunction

  // Synchronous table memory with read enable.
  always @(posedge clk) begin
`ifdef LDPC_RD_SEQ_PARCHK_EN
    if (table_rd_en) table_q <= {^t_word(int'(table_addr)), t_word(int'(table_addr))};
`else
    if (table_rd_en) table_q <= t_word(int'(table_addr));
`endif
  end

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({table_addr, table_rd_en, out_addr, out_rd, out_valid, out_last, busy, done, sel_err} !== '0) begin
      n_fail++;
      $display("FAIL reset: addr=%0d rd_en=%b oaddr=%0d ord=%h ov=%b ol=%b busy=%b done=%b se=%b, required all 0",
               table_addr, table_rd_en, out_addr, out_rd, out_valid, out_last, busy, done, sel_err);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy=%b ov=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_rate0();
    rate = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || table_rd_en !== 1'b1 || out_valid !== 1'b0 || table_addr !== 13'd0) begin
      n_fail++; $display("FAIL r0_after_E0: busy=%b rd_en=%b ov=%b addr=%0d, required 1 1 0 0",
                         busy, table_rd_en, out_valid, table_addr);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL r0_after_E1: ov=%b, required 0", out_valid); end
    @(negedge clk);
    for (int c = 0; c < 4608; c++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_addr !== e_addr(c) || out_rd !== e_rd(c) || out_last !== (c == 4607)) begin
        n_fail++;
        $display("FAIL r0_beat%0d: ov=%b addr=%0d rd=%h last=%b, required 1 %0d %h %b",
                 c, out_valid, out_addr, out_rd, out_last, e_addr(c), e_rd(c), (c == 4607));
      end
      @(negedge clk);
    end
    n_tests++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL r0_post_last: ov=%b done=%b busy=%b, required 0 0 1", out_valid, done, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL r0_done: done=%b busy=%b, required 1 0", done, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL r0_done_pulse: done=%b busy=%b, required 0 0", done, busy);
    end
`ifdef LDPC_RD_SEQ_PARCHK_EN
    n_tests++;
    if (par_err !== 1'b0) begin n_fail++; $display("FAIL r0_par_err: got %b, required 0", par_err); end
`endif
  endtask

  task automatic test_rate1_stall();
    int k = 0;
    int cyc;
    bit got_done = 0;
    logic rdy;
    rate = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0; rate = 2'd3;
    for (cyc = 0; cyc < 30000 && k < 6912; cyc++) begin
      rdy = (cyc % 3 != 2);
      out_ready = rdy;
      #1;
      if (out_valid === 1'b1) begin
        n_tests++;
        if (out_addr !== e_addr(k) || out_rd !== e_rd(k) || out_last !== (k == 6911)) begin
          n_fail++;
          $display("FAIL r1_beat%0d: addr=%0d rd=%h last=%b, required %0d %h %b",
                   k, out_addr, out_rd, out_last, e_addr(k), e_rd(k), (k == 6911));
        end
        if (!rdy) begin
          n_tests++;
          if (table_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL r1_stall_rd_en: got %b at beat %0d, required 0", table_rd_en, k);
          end
        end else k++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_tests++;
    if (k != 6912) begin n_fail++; $display("FAIL r1_beat_count: got %0d, required 6912", k); end
    for (int c = 0; c < 10 && !got_done; c++) begin
      if (done === 1'b1) got_done = 1;
      else @(negedge clk);
    end
    n_tests++;
    if (!got_done) begin n_fail++; $display("FAIL r1_done: no done pulse, required 1"); end
    @(negedge clk);
  endtask

  task automatic test_empty_rate();
    rate = 2'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0 || table_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL empty_in_done: busy=%b done=%b ov=%b rd_en=%b, required 1 0 0 0",
                         busy, done, out_valid, table_rd_en);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_done: done=%b busy=%b ov=%b, required 1 0 0", done, busy, out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_done_pulse: done=%b ov=%b, required 0 0", done, out_valid);
    end
  endtask

  task automatic test_sel_err();
    bad5 = 1'b1;
    rate = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);  // beat 4 now visible
    n_tests++;
    if (out_addr !== 8'd4 || sel_err !== 1'b0) begin
      n_fail++; $display("FAIL sel_before: addr=%0d se=%b, required 4 0", out_addr, sel_err);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_addr !== 8'd5 || out_rd !== 36'd0 || sel_err !== 1'b1) begin
      n_fail++; $display("FAIL sel_beat5: ov=%b addr=%0d rd=%h se=%b, required 1 5 0 1",
                         out_valid, out_addr, out_rd, sel_err);
    end
    @(negedge clk);
    n_tests++;
    if (out_addr !== 8'd6 || out_rd !== e_rd(6)) begin
      n_fail++; $display("FAIL sel_beat6: addr=%0d rd=%h, required 6 %h", out_addr, out_rd, e_rd(6));
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_tests++;
    if (sel_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL sel_sticky: se=%b busy=%b, required 1 0", sel_err, busy);
    end
    bad5 = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_tests++;
    if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_clear: got %b, required 0", sel_err); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_abort();
    rate = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (102) @(negedge clk);  // beat 100 visible
    n_tests++;
    if (out_valid !== 1'b1 || out_addr !== 8'd100) begin
      n_fail++; $display("FAIL abort_at100: ov=%b addr=%0d, required 1 100", out_valid, out_addr);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || table_addr !== 13'd0 || table_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_flush: ov=%b busy=%b addr=%0d rd_en=%b, required 0 0 0 0",
                         out_valid, busy, table_addr, table_rd_en);
    end
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_done%0d: done=%b ov=%b, required 0 0", c, done, out_valid);
      end
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_addr !== 8'd0 || out_rd !== e_rd(0)) begin
      n_fail++; $display("FAIL abort_replay: ov=%b addr=%0d rd=%h, required 1 0 %h",
                         out_valid, out_addr, out_rd, e_rd(0));
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    rate = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);  // beat 10 visible
    start = 1'b1; rate = 2'd1;
    for (int c = 10; c < 30; c++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_addr !== e_addr(c) || out_rd !== e_rd(c) || busy !== 1'b1) begin
        n_fail++; $display("FAIL restart_ignored_beat%0d: ov=%b addr=%0d rd=%h busy=%b, required 1 %0d %h 1",
                           c, out_valid, out_addr, out_rd, busy, e_addr(c), e_rd(c));
      end
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    start = 1'b1; rate = 2'd0;  // abort still high: start must lose
    @(negedge clk); start = 1'b0; abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || table_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL start_abort_same: busy=%b rd_en=%b, required 0 0", busy, table_rd_en);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_abort_idle: ov=%b done=%b busy=%b, required 0 0 0", out_valid, done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_rate0();
    test_rate1_stall();
    test_empty_rate();
    test_sel_err();
    test_abort();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
